// File: rtl/daq_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : daq_pkg
//  Description : Shared state encoding and sizing constants for the readout
//                responder and its serial word packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package daq_pkg;

  // Readout responder FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_TX = 3'd2,
    SHIFT   = 3'd3,
    FLUSH   = 3'd4,
    END     = 3'd5
  } state_t;

  // Default FIFO word width, which is also the deserialiser length
  localparam int DEFAULT_WORD_WIDTH = 16;

  // Width of the counter that waits for TransmitOn to rise
  localparam int TIMEOUT_CNT_W = 16;

endpackage : daq_pkg
`default_nettype wire

// File: rtl/serial_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_packer
//  Description : MSB-first deserialiser. Shifts din into the LSB on shift_en
//                and presents each completed word one cycle later with a
//                one-cycle word_valid. flush emits the partial word
//                left-aligned and zero-padded.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_word_packer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             flush,
  input  logic             din,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             pending
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] padded;
  logic [CNT_W:0]   pad_shift;
  logic             last_bit;

  assign shifted   = {sreg[WIDTH-2:0], din};
  assign last_bit  = (bit_cnt == CNT_W'(WIDTH - 1));
  // Partial word holds bit_cnt bits in its low end; move them to the top
  assign pad_shift = (CNT_W + 1)'(WIDTH) - {1'b0, bit_cnt};
  assign padded    = sreg << pad_shift;
  assign pending   = (bit_cnt != '0);

  // Shift register, bit counter and completed-word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg       <= '0;
      bit_cnt    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (flush) begin
        word       <= padded;
        word_valid <= 1'b1;
        bit_cnt    <= '0;
        sreg       <= '0;
      end else if (shift_en) begin
        sreg <= shifted;
        if (last_bit) begin
          word       <= shifted;
          word_valid <= 1'b1;
          bit_cnt    <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule : serial_word_packer
`default_nettype wire

// File: rtl/readout_responder.sv
`default_nettype none
// ============================================================================
//  Module      : readout_responder
//  Description : Responder side of the StartReadout/EndReadout handshake.
//                Pulses the ASIC START_READOUT pin, deserialises DOUT while
//                TransmitOn is high, writes packed words to the data FIFO and
//                returns a single-cycle EndReadout on completion or timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module readout_responder #(
  parameter int WORD_WIDTH         = daq_pkg::DEFAULT_WORD_WIDTH,
  parameter int START_PULSE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES     = 65535
) (
  input  logic                  Clk,
  input  logic                  reset_n,
  input  logic                  StartReadout,
  output logic                  EndReadout,
  output logic                  START_READOUT,
  input  logic                  TransmitOn,
  input  logic                  DOUT,
  output logic [WORD_WIDTH-1:0] FifoData,
  output logic                  FifoWrEn,
  input  logic                  FifoFull,
  output logic [15:0]           WordCount,
  output logic                  Overflow,
  output logic                  Timeout,
  output logic                  Busy
);

  import daq_pkg::*;

  localparam int PULSE_W = (START_PULSE_CYCLES > 1) ? $clog2(START_PULSE_CYCLES) : 1;

  state_t                   state_q;
  state_t                   state_d;
  logic [PULSE_W-1:0]       pulse_cnt;
  logic [TIMEOUT_CNT_W-1:0] tmo_cnt;
  logic                     pulse_last;
  logic                     tmo_last;
  logic                     start_req;
  logic                     set_timeout;
  logic                     shift_en;
  logic                     flush;
  logic                     word_valid;
  logic                     pending;

  assign pulse_last = (pulse_cnt == PULSE_W'(START_PULSE_CYCLES - 1));
  assign tmo_last   = (tmo_cnt == TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1));

  // TransmitOn arrives already restored to active-high after the pad ring
  serial_word_packer #(
    .WIDTH (WORD_WIDTH)
  ) u_packer (
    .clk        (Clk),
    .rst_n      (reset_n),
    .shift_en   (shift_en),
    .flush      (flush),
    .din        (DOUT),
    .word       (FifoData),
    .word_valid (word_valid),
    .pending    (pending)
  );

  // State register
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control strobes
  always_comb begin
    state_d     = state_q;
    start_req   = 1'b0;
    set_timeout = 1'b0;
    shift_en    = 1'b0;
    flush       = 1'b0;
    case (state_q)
      IDLE: begin
        if (StartReadout) begin
          start_req = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (pulse_last) begin
          state_d = WAIT_TX;
        end
      end
      WAIT_TX: begin
        // The bit present when TransmitOn rises is the first data bit
        if (TransmitOn) begin
          shift_en = 1'b1;
          state_d  = SHIFT;
        end else if (tmo_last) begin
          set_timeout = 1'b1;
          state_d     = END;
        end
      end
      SHIFT: begin
        if (TransmitOn) begin
          shift_en = 1'b1;
        end else if (pending) begin
          state_d = FLUSH;
        end else begin
          state_d = END;
        end
      end
      FLUSH: begin
        flush   = 1'b1;
        state_d = END;
      end
      END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore-decoded handshake outputs
  assign START_READOUT = (state_q == START);
  assign EndReadout    = (state_q == END);
  assign Busy          = (state_q != IDLE);

  // A word is written only when the FIFO can accept it
  assign FifoWrEn = word_valid & ~FifoFull;

  // START pulse length and TransmitOn timeout counters
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_cnt <= '0;
      tmo_cnt   <= '0;
    end else begin
      pulse_cnt <= (state_q == START) ? pulse_cnt + 1'b1 : '0;
      tmo_cnt   <= (state_q == WAIT_TX && !TransmitOn) ? tmo_cnt + 1'b1 : '0;
    end
  end

  // Per-readout word count and sticky status flags
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      WordCount <= '0;
      Overflow  <= 1'b0;
      Timeout   <= 1'b0;
    end else if (start_req) begin
      WordCount <= '0;
      Overflow  <= 1'b0;
      Timeout   <= 1'b0;
    end else begin
      if (set_timeout) begin
        Timeout <= 1'b1;
      end
      if (word_valid) begin
        if (FifoFull) begin
          Overflow <= 1'b1;
        end else if (WordCount != 16'hFFFF) begin
          WordCount <= WordCount + 16'd1;
        end
      end
    end
  end

endmodule : readout_responder
`default_nettype wire

// File: tb/tb_readout_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_readout_responder
//  Description : Scoreboard bench for readout_responder. Expected FIFO words
//                are queued by the stimulus; a negedge monitor pops and
//                compares every FIFO write.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_readout_responder;

  logic        Clk = 1'b0;
  logic        reset_n;
  logic        StartReadout;
  logic        EndReadout;
  logic        START_READOUT;
  logic        TransmitOn;
  logic        DOUT;
  logic [15:0] FifoData;
  logic        FifoWrEn;
  logic        FifoFull;
  logic [15:0] WordCount;
  logic        Overflow;
  logic        Timeout;
  logic        Busy;

  int compared   = 0;
  int mismatched = 0;
  int end_cnt    = 0;
  int sr_cycles  = 0;

  logic [15:0] exp_q[$];

  readout_responder #(
    .WORD_WIDTH         (16),
    .START_PULSE_CYCLES (4),
    .TIMEOUT_CYCLES     (100)
  ) dut (
    .Clk           (Clk),
    .reset_n       (reset_n),
    .StartReadout  (StartReadout),
    .EndReadout    (EndReadout),
    .START_READOUT (START_READOUT),
    .TransmitOn    (TransmitOn),
    .DOUT          (DOUT),
    .FifoData      (FifoData),
    .FifoWrEn      (FifoWrEn),
    .FifoFull      (FifoFull),
    .WordCount     (WordCount),
    .Overflow      (Overflow),
    .Timeout       (Timeout),
    .Busy          (Busy)
  );

  always #5 Clk = ~Clk;

  // Monitor: counts handshake pulses and checks every FIFO write
  always @(negedge Clk) begin
    if (EndReadout) end_cnt++;
    if (START_READOUT) sr_cycles++;
    if (FifoWrEn) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL fifo_write: actual %h, required no write", FifoData);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (FifoData !== e) begin
          mismatched++;
          $display("FAIL fifo_write: actual %h required %h", FifoData, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One full readout; bit i of the stream is data[nbits-1-i]
  task automatic run_readout(input logic [63:0] data, input int nbits,
                             input int full_lo, input int full_hi, input int sr_at,
                             input logic [15:0] exp_wc, input logic exp_ovf,
                             input string tag);
    int n;
    int e0;
    int s0;
    e0 = end_cnt;
    s0 = sr_cycles;
    StartReadout = 1'b1;
    tick();
    StartReadout = 1'b0;
    chk({tag, "_start_latency"}, START_READOUT, 1);
    chk({tag, "_flags_clear"}, {Overflow, Timeout, WordCount}, 0);
    n = 0;
    while (START_READOUT && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_pulse_len"}, n, 4);
    repeat (10) tick();
    for (int i = 0; i < nbits; i++) begin
      TransmitOn   = 1'b1;
      DOUT         = data[nbits-1-i];
      FifoFull     = (i >= full_lo && i <= full_hi);
      StartReadout = (i == sr_at);
      tick();
    end
    TransmitOn   = 1'b0;
    DOUT         = 1'b0;
    StartReadout = 1'b0;
    FifoFull     = (nbits >= full_lo && nbits <= full_hi);
    n = 0;
    while (!EndReadout && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_end_seen"}, EndReadout, 1);
    FifoFull = 1'b0;
    tick();
    chk({tag, "_busy_low"}, Busy, 0);
    chk({tag, "_word_count"}, WordCount, exp_wc);
    chk({tag, "_overflow"}, Overflow, exp_ovf);
    repeat (3) tick();
    chk({tag, "_end_pulses"}, end_cnt - e0, 1);
    chk({tag, "_start_cycles"}, sr_cycles - s0, 4);
    chk({tag, "_writes_done"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int e0;
    reset_n      = 1'b0;
    StartReadout = 1'b0;
    TransmitOn   = 1'b0;
    DOUT         = 1'b0;
    FifoFull     = 1'b0;
    repeat (2) tick();
    chk("reset_state",
        {EndReadout, START_READOUT, FifoWrEn, Overflow, Timeout, Busy, FifoData, WordCount}, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Nominal two-word transfer
    exp_q.push_back(16'hA5C3);
    exp_q.push_back(16'h0FF0);
    run_readout(64'hA5C3_0FF0, 32, 1000, -1, -1, 16'd2, 1'b0, "nominal");

    // Full word followed by a 4-bit partial word
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'hB000);
    run_readout(64'h1234B, 20, 1000, -1, -1, 16'd2, 1'b0, "partial");

    // Timeout with TransmitOn held low
    e0 = end_cnt;
    StartReadout = 1'b1;
    tick();
    StartReadout = 1'b0;
    n = 0;
    while (START_READOUT && n < 20) begin
      tick();
      n++;
    end
    n = 0;
    while (!EndReadout && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_latency", n, 100);
    chk("timeout_flag", Timeout, 1);
    chk("timeout_word_count", WordCount, 0);
    tick();
    chk("timeout_busy_low", Busy, 0);
    chk("timeout_sticky", Timeout, 1);
    chk("timeout_end_pulses", end_cnt - e0, 1);

    // FifoFull during the write of the second of three words
    exp_q.push_back(16'h1357);
    exp_q.push_back(16'h9ABC);
    run_readout(64'h1357_2468_9ABC, 48, 17, 32, -1, 16'd2, 1'b1, "overflow");
    repeat (3) tick();
    chk("overflow_sticky", Overflow, 1);

    // Reset asserted after 8 bits of SHIFT
    e0 = end_cnt;
    StartReadout = 1'b1;
    tick();
    StartReadout = 1'b0;
    chk("overflow_cleared", Overflow, 0);
    n = 0;
    while (START_READOUT && n < 20) begin
      tick();
      n++;
    end
    repeat (3) tick();
    for (int i = 0; i < 8; i++) begin
      TransmitOn = 1'b1;
      DOUT       = i[0];
      tick();
    end
    chk("reset_pre_busy", Busy, 1);
    reset_n = 1'b0;
    #1;
    chk("reset_mid_shift",
        {EndReadout, START_READOUT, FifoWrEn, Overflow, Timeout, Busy, FifoData, WordCount}, 0);
    TransmitOn = 1'b0;
    DOUT       = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    chk("reset_no_end", end_cnt - e0, 0);
    chk("reset_idle", Busy, 0);

    // Normal readout after the aborted one
    exp_q.push_back(16'hDEAD);
    exp_q.push_back(16'hBEEF);
    run_readout(64'hDEAD_BEEF, 32, 1000, -1, -1, 16'd2, 1'b0, "post_reset");

    // StartReadout during SHIFT must be ignored
    exp_q.push_back(16'h5A5A);
    exp_q.push_back(16'hC3C3);
    run_readout(64'h5A5A_C3C3, 32, 1000, -1, 24, 16'd2, 1'b0, "ignored");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_readout_responder
`default_nettype wire

// File: doc/readout_responder.md
Name: readout_responder

Overview:
- Responder end of the StartReadout/EndReadout handshake that the DAQ mode switcher routes from the selected DAQ controller.
- On a StartReadout pulse it pulses the ASIC START_READOUT pin, then deserialises DOUT while TransmitOn is high.
- It packs the bits into words written to the data FIFO, and returns a single-cycle EndReadout when the chain has finished or has timed out.

Parameters:
- WORD_WIDTH, 16, FIFO word width and deserialiser length.
- START_PULSE_CYCLES, 4, number of Clk cycles START_READOUT is held high.
- TIMEOUT_CYCLES, 65535, maximum Clk cycles waiting for TransmitOn to rise; counter is 16 bits.

Ports:
- Clk  in  1  system clock; DOUT and TransmitOn are synchronous to it.
- reset_n  in  1  asynchronous active-low reset.
- StartReadout  in  1  single-cycle request from the switcher.
- EndReadout  out  1  single-cycle completion pulse to the switcher.
- START_READOUT  out  1  ASIC readout start pin, active high.
- TransmitOn  in  1  ASIC transmit window, active high; inverted in the pad ring.
- DOUT  in  1  ASIC serial data, MSB of each word first.
- FifoData  out  WORD_WIDTH  word to the data FIFO.
- FifoWrEn  out  1  FIFO write strobe, one cycle per word.
- FifoFull  in  1  FIFO full flag.
- WordCount  out  16  words accepted in the current readout.
- Overflow  out  1  sticky: at least one word was dropped because FifoFull was high.
- Timeout  out  1  sticky: TransmitOn never rose within TIMEOUT_CYCLES.
- Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, reset_n low) forces:
  - state IDLE;
  - all outputs 0, including FifoData, WordCount, Overflow and Timeout;
  - shift register and bit counter cleared.
- A reset asserted mid-operation aborts immediately. No EndReadout is issued and no partial word is written.
- IDLE:
  - StartReadout=1 clears WordCount, Overflow and Timeout; next state is START.
  - StartReadout is ignored in every other state.
- START:
  - START_READOUT=1 for exactly START_PULSE_CYCLES cycles, then the block goes to WAIT_TX.
- WAIT_TX:
  - TransmitOn=1 goes to SHIFT, and the bit on DOUT in that same cycle is captured as the first bit.
  - When the timeout counter reaches TIMEOUT_CYCLES-1 with no TransmitOn, Timeout is set and the block goes to END.
- SHIFT:
  - Each cycle with TransmitOn=1 shifts DOUT into the LSB; the earliest bit ends up as the MSB.
  - When the bit counter reaches WORD_WIDTH-1, the completed word is presented on FifoData with FifoWrEn=1 in the next cycle, and the bit counter wraps to 0.
  - A word completes and is written with zero bubble, so back-to-back words are written every WORD_WIDTH cycles.
  - TransmitOn falling with the bit counter at 0 goes to END.
  - TransmitOn falling with a nonzero bit counter goes to FLUSH.
- FLUSH:
  - The partial word is left-aligned and zero-padded in the low bits, then written once.
  - Next state is END.
- Write rule:
  - When FifoFull=1 in the write cycle, FifoWrEn stays 0, Overflow is set and WordCount does not increment.
  - Otherwise WordCount increments, saturating at 0xFFFF.
- END:
  - EndReadout=1 for one cycle, then the block returns to IDLE.
  - Busy falls in the cycle after EndReadout.
- Simultaneous events:
  - If a word completes in the same cycle TransmitOn falls, the full word is written and the block goes to END; FLUSH is not entered.
  - StartReadout arriving in END is ignored.
- Total latency from StartReadout to the first START_READOUT high is 1 cycle.

Decomposition:
- Shared package (daq_pkg) holds:
  - the state encoding constants IDLE, START, WAIT_TX, SHIFT, FLUSH, END;
  - WORD_WIDTH and the timeout counter width.
- One natural sub-module: serial_word_packer.
  - Contains the shift register, bit counter, word-complete flag and flush/pad logic.
  - Controlled by shift_en and flush, and outputs word and word_valid.
- The FSM, counters and FIFO write gating stay in the top module.

Test Plan:
- Nominal:
  - Stimulus: StartReadout pulse; TransmitOn rises 10 cycles after START_READOUT falls and stays high for 32 cycles; DOUT carries 0xA5C3 then 0x0FF0.
  - Required: START_READOUT high for 4 cycles; two writes of 0xA5C3 then 0x0FF0; WordCount=2; a single EndReadout pulse; Overflow=0.
- Partial word:
  - Stimulus: TransmitOn high for 20 cycles; bits are 0x1234 followed by 1011.
  - Required: writes 0x1234 then 0xB000; WordCount=2.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=100; TransmitOn held at 0.
  - Required: Timeout=1; EndReadout pulses 100 cycles after entering WAIT_TX; no FIFO writes; WordCount=0.
- Overflow:
  - Stimulus: FifoFull=1 during the second word of a 3-word transfer.
  - Required: only words 1 and 3 are written; WordCount=2; Overflow=1 until the next StartReadout.
- Reset mid-SHIFT:
  - Stimulus: reset_n pulsed low after 8 bits have been shifted.
  - Required: all outputs 0 immediately; no EndReadout; a subsequent StartReadout runs a normal readout.
- Ignored request:
  - Stimulus: StartReadout while Busy=1 in SHIFT.
  - Required: no restart; WordCount is not cleared; exactly one EndReadout.
